// File: rtl/pc_tt_pkg.sv
//==============================================================================
// Module  : pc_tt_pkg
// Brief   : Shared types and constants for the programmable PC target table.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package pc_tt_pkg;

    localparam int D_DEF  = 10;
    localparam int AW_DEF = 4;

    typedef struct packed {
        logic             valid;
        logic             rel;
        logic [D_DEF-1:0] value;
    } pc_tt_entry_t;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } pc_tt_state_e;

    localparam pc_tt_entry_t PC_TT_ENTRY_CLR = '{valid: 1'b0, rel: 1'b0, value: '0};

endpackage

`default_nettype wire

// File: rtl/pc_tt_tgt_calc.sv
//==============================================================================
// Module  : pc_tt_tgt_calc
// Brief   : Resolves a table entry and current PC into target/hit/rel.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module pc_tt_tgt_calc #(
    parameter int D = 10
) (
    input  logic         entry_valid_i,
    input  logic         entry_rel_i,
    input  logic [D-1:0] entry_value_i,
    input  logic [D-1:0] pc_i,
    output logic [D-1:0] tgt_o,
    output logic         hit_o,
    output logic         rel_o
);

    // D-bit adds wrap modulo 2**D; the offset is two's complement so a plain add suffices
    always_comb begin
        tgt_o = pc_i + D'(1);
        hit_o = 1'b0;
        rel_o = 1'b0;
        if (entry_valid_i) begin
            hit_o = 1'b1;
            rel_o = entry_rel_i;
            tgt_o = entry_rel_i ? (pc_i + entry_value_i) : entry_value_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_target_table.sv
//==============================================================================
// Module  : pc_target_table
// Brief   : Run-time loadable branch-target table, absolute/relative entries,
//           registered 1-cycle lookup. Define PC_TT_FWD_EN to forward a
//           same-cycle write to a lookup of the same index.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module pc_target_table
    import pc_tt_pkg::*;
#(
    parameter int D  = D_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          ready,
    input  logic          lkp_valid,
    input  logic [AW-1:0] lkp_addr,
    input  logic [D-1:0]  lkp_pc,
    output logic          tgt_valid,
    output logic [D-1:0]  tgt,
    output logic          tgt_hit,
    output logic          tgt_rel,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [D-1:0]  wr_data,
    input  logic          wr_rel
);

    localparam int DEPTH = 1 << AW;

    pc_tt_state_e  state_q;
    logic [AW-1:0] init_idx_q;
    logic          ready_q;
    logic          tgt_valid_q;
    logic [D-1:0]  tgt_q;
    logic          tgt_hit_q;
    logic          tgt_rel_q;

    logic          ent_valid_q [DEPTH];
    logic          ent_rel_q   [DEPTH];
    logic [D-1:0]  ent_value_q [DEPTH];

    logic          mem_we_d;
    logic [AW-1:0] mem_idx_d;
    logic          mem_valid_d;
    logic          mem_rel_d;
    logic [D-1:0]  mem_value_d;

    logic          rd_valid_d;
    logic          rd_rel_d;
    logic [D-1:0]  rd_value_d;

    logic [D-1:0]  calc_tgt;
    logic          calc_hit;
    logic          calc_rel;

    logic          w_is_ready;

    assign w_is_ready = (state_q == READY);

    // The single RAM write port is shared between the INIT sweep and the loader
    always_comb begin
        mem_we_d    = 1'b0;
        mem_idx_d   = init_idx_q;
        mem_valid_d = PC_TT_ENTRY_CLR.valid;
        mem_rel_d   = PC_TT_ENTRY_CLR.rel;
        mem_value_d = D'(PC_TT_ENTRY_CLR.value);
        if (!w_is_ready) begin
            mem_we_d = 1'b1;
        end else if (wr_en) begin
            mem_we_d    = 1'b1;
            mem_idx_d   = wr_addr;
            mem_valid_d = 1'b1;
            mem_rel_d   = wr_rel;
            mem_value_d = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            ent_valid_q[mem_idx_d] <= mem_valid_d;
            ent_rel_q[mem_idx_d]   <= mem_rel_d;
            ent_value_q[mem_idx_d] <= mem_value_d;
        end
    end

    always_comb begin
        rd_valid_d = ent_valid_q[lkp_addr];
        rd_rel_d   = ent_rel_q[lkp_addr];
        rd_value_d = ent_value_q[lkp_addr];
`ifdef PC_TT_FWD_EN
        if (wr_en && (wr_addr == lkp_addr)) begin
            rd_valid_d = 1'b1;
            rd_rel_d   = wr_rel;
            rd_value_d = wr_data;
        end
`endif
    end

    pc_tt_tgt_calc #(
        .D (D)
    ) u_tgt_calc (
        .entry_valid_i (rd_valid_d),
        .entry_rel_i   (rd_rel_d),
        .entry_value_i (rd_value_d),
        .pc_i          (lkp_pc),
        .tgt_o         (calc_tgt),
        .hit_o         (calc_hit),
        .rel_o         (calc_rel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            init_idx_q  <= '0;
            ready_q     <= 1'b0;
            tgt_valid_q <= 1'b0;
            tgt_q       <= '0;
            tgt_hit_q   <= 1'b0;
            tgt_rel_q   <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    tgt_valid_q <= 1'b0;
                    init_idx_q  <= init_idx_q + AW'(1);
                    if (init_idx_q == AW'(DEPTH - 1)) begin
                        state_q <= READY;
                        ready_q <= 1'b1;
                    end
                end
                READY: begin
                    tgt_valid_q <= lkp_valid;
                    if (lkp_valid) begin
                        tgt_q     <= calc_tgt;
                        tgt_hit_q <= calc_hit;
                        tgt_rel_q <= calc_rel;
                    end
                end
                default: begin
                    state_q <= INIT;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready     = ready_q;
    assign tgt_valid = tgt_valid_q;
    assign tgt       = tgt_q;
    assign tgt_hit   = tgt_hit_q;
    assign tgt_rel   = tgt_rel_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_target_table.sv
//==============================================================================
// Module  : tb_pc_target_table
// Brief   : Self-checking bench for pc_target_table (model + directed vectors).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pc_target_table;

    localparam int D     = 10;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int MOD   = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          ready;
    logic          lkp_valid = 1'b0;
    logic [AW-1:0] lkp_addr = '0;
    logic [D-1:0]  lkp_pc = '0;
    logic          tgt_valid;
    logic [D-1:0]  tgt;
    logic          tgt_hit;
    logic          tgt_rel;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [D-1:0]  wr_data = '0;
    logic          wr_rel = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pc_target_table #(.D(D), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ready     (ready),
        .lkp_valid (lkp_valid),
        .lkp_addr  (lkp_addr),
        .lkp_pc    (lkp_pc),
        .tgt_valid (tgt_valid),
        .tgt       (tgt),
        .tgt_hit   (tgt_hit),
        .tgt_rel   (tgt_rel),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_rel    (wr_rel)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: table as plain arrays, targets from integer arithmetic
    bit m_valid [DEPTH];
    bit m_rel   [DEPTH];
    int m_val   [DEPTH];
    int m_edges = 0;
    bit e_ready = 0, e_tv = 0, e_hit = 0, e_rel = 0;
    int e_tgt = 0;
    bit mv, mr;
    int mval;

    function automatic int resolve(bit v, bit r, int val, int pc);
        int s;
        if (!v) return (pc + 1) % MOD;
        if (!r) return val;
        s = (val >= MOD / 2) ? val - MOD : val;
        return (((pc + s) % MOD) + MOD) % MOD;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_ready = 0; e_tv = 0; e_tgt = 0; e_hit = 0; e_rel = 0;
            m_edges = 0;
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
        end else if (!e_ready) begin
            m_edges++;
            e_tv = 0;
            if (m_edges == DEPTH) e_ready = 1;
        end else begin
            if (lkp_valid) begin
                mv   = m_valid[lkp_addr];
                mr   = m_rel[lkp_addr];
                mval = m_val[lkp_addr];
`ifdef PC_TT_FWD_EN
                if (wr_en && wr_addr == lkp_addr) begin
                    mv = 1; mr = wr_rel; mval = int'(wr_data);
                end
`endif
                e_tgt = resolve(mv, mr, mval, int'(lkp_pc));
                e_hit = mv;
                e_rel = mv && mr;
            end
            e_tv = lkp_valid;
            if (wr_en) begin
                m_valid[wr_addr] = 1;
                m_rel[wr_addr]   = wr_rel;
                m_val[wr_addr]   = int'(wr_data);
            end
        end
    end

    always @(negedge clk) begin
        check("ready", ready, e_ready);
        check("tgt_valid", tgt_valid, e_tv);
        check("tgt", tgt, e_tgt);
        check("tgt_hit", tgt_hit, e_hit);
        check("tgt_rel", tgt_rel, e_rel);
    end

    // One-cycle operation; returns at posedge+1 where the lookup result is visible
    task automatic cyc(input bit we, input int wa, input int wd, input bit wrl,
                       input bit le, input int la, input int pc);
        wr_en = we; wr_addr = AW'(wa); wr_data = D'(wd); wr_rel = wrl;
        lkp_valid = le; lkp_addr = AW'(la); lkp_pc = D'(pc);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        lkp_valid = 1'b0;
    endtask

    task automatic lk(input string name, input int la, input int pc,
                      input int et, input bit eh, input bit er);
        cyc(0, 0, 0, 0, 1, la, pc);
        check({name, "_valid"}, tgt_valid, 1);
        check({name, "_tgt"}, tgt, et);
        check({name, "_hit"}, tgt_hit, eh);
        check({name, "_rel"}, tgt_rel, er);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready, 0);
        check("rst_tgt_valid", tgt_valid, 0);
        check("rst_tgt", tgt, 0);
        // Lookups and writes held during INIT must be ignored
        lkp_valid = 1'b1; lkp_addr = 4'd3; lkp_pc = 10'd7;
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 10'd55; wr_rel = 1'b0;
        rst_n = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            @(posedge clk);
            #1;
            check("init_ready", ready, (i == DEPTH) ? 1 : 0);
            check("init_tgt_valid", tgt_valid, 0);
        end
        lkp_valid = 1'b0; wr_en = 1'b0;

        lk("init_nowrite", 3, 7, 8, 0, 0);

        cyc(1, 3, 68, 0, 0, 0, 0);
        lk("abs3", 3, 20, 68, 1, 0);

        cyc(1, 9, 'h3FB, 1, 0, 0, 0);
        lk("rel9_wrap", 9, 4, 1023, 1, 1);
        lk("rel9", 9, 20, 15, 1, 1);

        lk("miss5_wrap", 5, 1023, 0, 0, 0);

        cyc(1, 2, 113, 0, 0, 0, 0);
        cyc(1, 2, 80, 0, 1, 2, 50);
`ifdef PC_TT_FWD_EN
        check("collide_tgt", tgt, 80);
`else
        check("collide_tgt", tgt, 113);
`endif
        check("collide_hit", tgt_hit, 1);
        lk("after_collide", 2, 50, 80, 1, 0);

        cyc(1, 7, 300, 1, 1, 3, 0);
        check("diff_idx_tgt", tgt, 68);
        lk("rel7", 7, 100, 400, 1, 1);

        @(posedge clk);
        #1;
        check("hold_valid", tgt_valid, 0);
        check("hold_tgt", tgt, 400);
        check("hold_rel", tgt_rel, 1);

        // Back-to-back stream, then reset mid-stream
        lkp_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            lkp_addr = AW'((i * 5) % DEPTH);
            lkp_pc   = D'(i * 37 + 5);
            @(posedge clk);
            #1;
            check("stream_valid", tgt_valid, 1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ready", ready, 0);
        check("midrst_tgt_valid", tgt_valid, 0);
        check("midrst_tgt", tgt, 0);
        lkp_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (DEPTH) @(posedge clk);
        #1;
        check("reinit_ready", ready, 1);
        lk("reinit_miss3", 3, 200, 201, 0, 0);
        lk("reinit_miss9", 9, 1023, 0, 0, 0);

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
